// File: rtl/level_seq_pkg.sv
// Shared types and defaults for the obstacle-game level sequencer.
// stage_len() yields the per-level stage length, clamped to a floor.
package level_seq_pkg;

    typedef enum logic [2:0] {
        StMenu,
        StMenuArm,
        StStage,
        StFinale,
        StWinArm,
        StWin,
        StOver
    } lvl_state_t;

    localparam int unsigned DefNumStages = 7;
    localparam int unsigned DefNumLevels = 3;
    localparam int unsigned DefLives     = 3;
    localparam int unsigned DefTimeW     = 11;
    localparam int unsigned DefStageLen  = 130;
    localparam int unsigned DefStageDec  = 20;
    localparam int unsigned DefMinStage  = 40;
    localparam int unsigned DefFinaleLen = 390;

    // Signed 32-bit arithmetic: a large level*dec goes negative instead of wrapping,
    // and 32 bits covers TIME_W+4 for any practical counter width.
    function automatic int stage_len(input int level,
                                     input int len0    = DefStageLen,
                                     input int dec     = DefStageDec,
                                     input int min_len = DefMinStage);
        int raw;
        raw = len0 - level * dec;
        return (raw < min_len) ? min_len : raw;
    endfunction

endpackage

// File: rtl/level_sequencer_stage_timer.sv
// Tick-enabled stage counter with clear and terminal-count strobe.
// tc_o fires on the enabled tick that completes len_i counts; the counter wraps to 0 there.
module stage_timer #(
    parameter int unsigned W = 11
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic [W-1:0] len_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        tc_o  = en_i && (cnt_q == len_i - W'(1));
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tc_o ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/level_sequencer.sv
// Level/stage progression, lives and screen selection for the obstacle game.
// All outputs decode from registers; inputs never reach outputs combinationally.
module level_sequencer
    import level_seq_pkg::*;
#(
    parameter int unsigned NUM_STAGES = DefNumStages,
    parameter int unsigned NUM_LEVELS = DefNumLevels,
    parameter int unsigned LIVES      = DefLives,
    parameter int unsigned TIME_W     = DefTimeW,
    parameter int unsigned STAGE_LEN  = DefStageLen,
    parameter int unsigned STAGE_DEC  = DefStageDec,
    parameter int unsigned MIN_STAGE  = DefMinStage,
    parameter int unsigned FINALE_LEN = DefFinaleLen
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              tick,
    input  logic                              user_sel,
    input  logic                              player_died,
    output logic [NUM_STAGES-1:0]             stage_en,
    output logic [$clog2(NUM_STAGES)-1:0]     stage_idx,
    output logic                              obj_reset,
    output logic                              player_done,
    output logic [$clog2(NUM_LEVELS+1)-1:0]   level,
    output logic [$clog2(LIVES+1)-1:0]        lives_left,
    output logic [TIME_W-1:0]                 game_time,
    output logic                              menu_screen,
    output logic                              win_screen,
    output logic                              over_screen
);

    localparam int unsigned IdxW = $clog2(NUM_STAGES);
    localparam int unsigned LvlW = $clog2(NUM_LEVELS + 1);
    localparam int unsigned LivW = $clog2(LIVES + 1);

    lvl_state_t        state_q, state_d;
    logic [LvlW-1:0]   level_q, level_d;
    logic [LivW-1:0]   lives_q, lives_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [TIME_W-1:0] gt_q, gt_d;
    logic              obj_q, obj_d;

    logic              active, tmr_en, tmr_clr, tmr_tc;
    logic [TIME_W-1:0] cur_len, tmr_len, tmr_cnt;

    assign cur_len = TIME_W'(stage_len(int'(level_q), int'(STAGE_LEN), int'(STAGE_DEC),
                                       int'(MIN_STAGE)));
    assign active  = (state_q == StStage) || (state_q == StFinale);
    // A death in the same cycle as a tick must not let the timer expire the stage.
    assign tmr_en  = active && tick && !player_died;
    assign tmr_len = (state_q == StFinale) ? TIME_W'(FINALE_LEN) : cur_len;

    stage_timer #(
        .W (TIME_W)
    ) u_timer (
        .clk_i   (clk),
        .reset_i (reset),
        .en_i    (tmr_en),
        .clr_i   (tmr_clr),
        .len_i   (tmr_len),
        .cnt_o   (tmr_cnt),
        .tc_o    (tmr_tc)
    );

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        lives_d = lives_q;
        idx_d   = idx_q;
        gt_d    = gt_q;
        obj_d   = 1'b0;
        tmr_clr = 1'b0;
        unique case (state_q)
            StMenu: if (user_sel) state_d = StMenuArm;
            StMenuArm: begin
                if (user_sel) begin
                    state_d = StStage;
                    level_d = '0;
                    lives_d = LivW'(LIVES);
                    idx_d   = '0;
                    gt_d    = '0;
                    obj_d   = 1'b1;
                    tmr_clr = 1'b1;
                end
            end
            StStage, StFinale: begin
                if (player_died) begin
                    tmr_clr = 1'b1;
                    if (lives_q > LivW'(1)) begin
                        state_d = StStage;
                        lives_d = lives_q - LivW'(1);
                        idx_d   = '0;
                        gt_d    = '0;
                        obj_d   = 1'b1;
                    end else begin
                        state_d = StOver;
                        lives_d = '0;
                    end
                end else if (tick) begin
                    gt_d = (gt_q == '1) ? gt_q : gt_q + TIME_W'(1);
                    if (tmr_tc && state_q == StStage) begin
                        obj_d = 1'b1;
                        if (idx_q == IdxW'(NUM_STAGES - 1)) state_d = StFinale;
                        else                                 idx_d   = idx_q + IdxW'(1);
                    end else if (tmr_tc) begin
                        if (level_q == LvlW'(NUM_LEVELS - 1)) begin
                            state_d = StWinArm;
                        end else begin
                            state_d = StStage;
                            level_d = level_q + LvlW'(1);
                            idx_d   = '0;
                            gt_d    = '0;
                            obj_d   = 1'b1;
                        end
                    end
                end
            end
            StWinArm: if (user_sel) state_d = StWin;
            StWin:    if (user_sel) state_d = StMenu;
            StOver:   if (user_sel) state_d = StMenu;
            default:  state_d = StMenu;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StMenu;
            level_q <= '0;
            lives_q <= LivW'(LIVES);
            idx_q   <= '0;
            gt_q    <= '0;
            obj_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            lives_q <= lives_d;
            idx_q   <= idx_d;
            gt_q    <= gt_d;
            obj_q   <= obj_d;
        end
    end

    assign stage_en    = (state_q == StStage) ? (NUM_STAGES'(1) << idx_q) : '0;
    assign stage_idx   = idx_q;
    assign obj_reset   = obj_q;
    assign player_done = (state_q == StFinale) || (state_q == StWinArm) || (state_q == StWin);
    assign level       = level_q;
    assign lives_left  = lives_q;
    assign game_time   = gt_q;
    assign menu_screen = (state_q == StMenu) || (state_q == StMenuArm);
    assign win_screen  = (state_q == StWinArm) || (state_q == StWin);
    assign over_screen = (state_q == StOver);

endmodule

// File: tb/tb_level_sequencer.sv
// Scoreboard bench: stimulus queues expected snapshots; a monitor compares them on each
// obj_reset pulse and on explicit probe cycles.
module tb_level_sequencer;

    typedef struct {
        int          tag;
        logic [6:0]  en;
        logic [2:0]  idx;
        bit          chk_idx;
        logic [1:0]  lvl;
        logic [1:0]  lives;
        logic [10:0] gt;
        bit          chk_gt;
        logic        pd;
        logic        menu;
        logic        win;
        logic        over;
        logic        objr;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1, tick = 1'b0, user_sel = 1'b0, player_died = 1'b0;
    logic sel = 1'b0, probe_req = 1'b0, end_req = 1'b0;

    logic [6:0]  a_en, b_en, m_en;
    logic [2:0]  a_idx, b_idx, m_idx;
    logic [1:0]  a_lvl, b_lvl, m_lvl, a_liv, b_liv, m_liv;
    logic [10:0] a_gt, b_gt, m_gt;
    logic a_obj, b_obj, m_obj, a_pd, b_pd, m_pd;
    logic a_mn, b_mn, m_mn, a_wn, b_wn, m_wn, a_ov, b_ov, m_ov;

    exp_t obj_q[$];
    exp_t probe_q[$];
    int   compared = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    level_sequencer u_dut_a (
        .clk(clk), .reset(reset), .tick(tick), .user_sel(user_sel), .player_died(player_died),
        .stage_en(a_en), .stage_idx(a_idx), .obj_reset(a_obj), .player_done(a_pd),
        .level(a_lvl), .lives_left(a_liv), .game_time(a_gt),
        .menu_screen(a_mn), .win_screen(a_wn), .over_screen(a_ov)
    );

    // Steep decrement: level 1 raw length 30, level 2 raw length -70; both clamp to 40.
    level_sequencer #(
        .STAGE_DEC (100)
    ) u_dut_b (
        .clk(clk), .reset(reset), .tick(tick), .user_sel(user_sel), .player_died(player_died),
        .stage_en(b_en), .stage_idx(b_idx), .obj_reset(b_obj), .player_done(b_pd),
        .level(b_lvl), .lives_left(b_liv), .game_time(b_gt),
        .menu_screen(b_mn), .win_screen(b_wn), .over_screen(b_ov)
    );

    assign m_en  = sel ? b_en  : a_en;
    assign m_idx = sel ? b_idx : a_idx;
    assign m_lvl = sel ? b_lvl : a_lvl;
    assign m_liv = sel ? b_liv : a_liv;
    assign m_gt  = sel ? b_gt  : a_gt;
    assign m_obj = sel ? b_obj : a_obj;
    assign m_pd  = sel ? b_pd  : a_pd;
    assign m_mn  = sel ? b_mn  : a_mn;
    assign m_wn  = sel ? b_wn  : a_wn;
    assign m_ov  = sel ? b_ov  : a_ov;

    task automatic check(input exp_t e);
        bit bad;
        compared++;
        bad = (m_en !== e.en) || (e.chk_idx && m_idx !== e.idx) || (m_lvl !== e.lvl) ||
              (m_liv !== e.lives) || (e.chk_gt && m_gt !== e.gt) || (m_pd !== e.pd) ||
              (m_mn !== e.menu) || (m_wn !== e.win) || (m_ov !== e.over) ||
              (m_obj !== e.objr);
        if (bad) begin
            mismatched++;
            $display("FAIL snap%0d dut%0d: got en=%b idx=%0d lvl=%0d lives=%0d gt=%0d pd=%b mwo=%b%b%b obj=%b; want en=%b idx=%0d lvl=%0d lives=%0d gt=%0d pd=%b mwo=%b%b%b obj=%b",
                     e.tag, sel, m_en, m_idx, m_lvl, m_liv, m_gt, m_pd, m_mn, m_wn, m_ov, m_obj,
                     e.en, e.idx, e.lvl, e.lives, e.gt, e.pd, e.menu, e.win, e.over, e.objr);
        end
    endtask

    always @(negedge clk) begin
        if (m_obj) begin
            if (obj_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_obj_reset at %0t: got pulse, want none", $time);
            end else begin
                check(obj_q.pop_front());
            end
        end
        if (probe_req && probe_q.size() != 0) check(probe_q.pop_front());
        if (end_req) begin
            compared++;
            if (obj_q.size() != 0) begin
                mismatched++;
                $display("FAIL missing_obj_reset: got %0d pending, want 0 (next snap%0d)",
                         obj_q.size(), obj_q[0].tag);
                obj_q.delete();
            end
        end
    end

    function automatic exp_t snap(input int tag, input int en, input int idx, input bit ci,
                                  input int lvl, input int lives, input int gt, input bit cg,
                                  input bit pd, input bit menu, input bit win, input bit over);
        exp_t e;
        e.tag = tag;    e.en = 7'(en);     e.idx = 3'(idx);   e.chk_idx = ci;
        e.lvl = 2'(lvl); e.lives = 2'(lives); e.gt = 11'(gt); e.chk_gt = cg;
        e.pd = pd; e.menu = menu; e.win = win; e.over = over; e.objr = 1'b0;
        return e;
    endfunction

    task automatic push_obj(input int tag, input int idx, input int lvl, input int lives,
                            input int gt);
        exp_t e;
        e = snap(tag, 1 << idx, idx, 1'b1, lvl, lives, gt, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        e.objr = 1'b1;
        obj_q.push_back(e);
    endtask

    task automatic push_fin(input int tag, input int lvl, input int lives, input int gt);
        exp_t e;
        e = snap(tag, 0, 0, 1'b0, lvl, lives, gt, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        e.objr = 1'b1;
        obj_q.push_back(e);
    endtask

    task automatic step(input logic t, input logic s, input logic d);
        tick = t; user_sel = s; player_died = d;
        @(posedge clk);
        #1;
        tick = 1'b0; user_sel = 1'b0; player_died = 1'b0;
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
    endtask

    task automatic probe(input exp_t e);
        probe_q.push_back(e);
        probe_req = 1'b1;
        @(posedge clk);
        #1;
        probe_req = 1'b0;
    endtask

    // Stages 1..6 and finale entry of one level; the caller is at stage 0 with timers at 0.
    task automatic play_stages(input int len, input int lvl, input int lives, input int tag);
        for (int k = 1; k < 7; k++) begin
            push_obj(tag + k, k, lvl, lives, len * k);
            run_ticks(len);
        end
        push_fin(tag + 7, lvl, lives, len * 7);
        run_ticks(len);
    endtask

    task automatic play_level(input int len, input int lvl, input int lives, input bit last,
                              input int tag);
        play_stages(len, lvl, lives, tag);
        if (!last) push_obj(tag + 8, 0, lvl + 1, lives, 0);
        run_ticks(390);
    endtask

    task automatic start_game(input int tag);
        step(1'b0, 1'b1, 1'b0);
        push_obj(tag, 0, 0, 3, 0);
        step(1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        // Reset state and menu arming
        step(1'b0, 1'b0, 1'b0);
        probe(snap(1, 0, 0, 1, 0, 3, 0, 1, 0, 1, 0, 0));
        reset = 1'b0;
        step(1'b1, 1'b0, 1'b1);
        probe(snap(2, 0, 0, 1, 0, 3, 0, 1, 0, 1, 0, 0));
        start_game(3);

        // Level 0 at 130 ticks/stage, boundary at tick 129
        run_ticks(129);
        probe(snap(4, 1, 0, 1, 0, 3, 129, 1, 0, 0, 0, 0));
        push_obj(5, 1, 0, 3, 130);
        run_ticks(1);
        for (int k = 2; k < 7; k++) begin
            push_obj(10 + k, k, 0, 3, 130 * k);
            run_ticks(130);
        end
        push_fin(20, 0, 3, 910);
        run_ticks(130);
        run_ticks(389);
        probe(snap(21, 0, 0, 0, 0, 3, 1299, 1, 1, 0, 0, 0));
        push_obj(22, 0, 1, 3, 0);
        run_ticks(1);

        // Level 1 at 110 ticks/stage
        run_ticks(109);
        probe(snap(23, 1, 0, 1, 1, 3, 109, 1, 0, 0, 0, 0));
        push_obj(24, 1, 1, 3, 110);
        run_ticks(1);
        for (int k = 2; k < 5; k++) begin
            push_obj(30 + k, k, 1, 3, 110 * k);
            run_ticks(110);
        end

        // Death at stage 4, then death coinciding with an expiring tick
        run_ticks(5);
        push_obj(40, 0, 1, 2, 0);
        step(1'b0, 1'b0, 1'b1);
        run_ticks(109);
        push_obj(41, 0, 1, 1, 0);
        step(1'b1, 1'b0, 1'b1);
        run_ticks(109);
        probe(snap(42, 1, 0, 1, 1, 1, 109, 1, 0, 0, 0, 0));
        push_obj(43, 1, 1, 1, 110);
        run_ticks(1);

        // Last life lost -> OVER; stray inputs ignored; user_sel -> MENU
        step(1'b0, 1'b0, 1'b1);
        probe(snap(44, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1));
        step(1'b1, 1'b0, 1'b1);
        probe(snap(45, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1));
        step(1'b0, 1'b1, 1'b0);
        probe(snap(46, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0));

        // Full game to the win screen: 130, 110, 90 ticks per stage
        start_game(50);
        play_level(130, 0, 3, 1'b0, 100);
        play_level(110, 1, 3, 1'b0, 200);
        play_level(90, 2, 3, 1'b1, 300);
        probe(snap(60, 0, 0, 0, 2, 3, 1020, 1, 1, 0, 1, 0));
        run_ticks(5);
        step(1'b0, 1'b0, 1'b1);
        probe(snap(61, 0, 0, 0, 2, 3, 1020, 1, 1, 0, 1, 0));
        step(1'b0, 1'b1, 1'b0);
        probe(snap(62, 0, 0, 0, 2, 3, 1020, 1, 1, 0, 1, 0));
        step(1'b0, 1'b1, 1'b0);
        probe(snap(63, 0, 0, 0, 2, 3, 1020, 1, 0, 1, 0, 0));

        // Reset in the middle of the finale
        start_game(70);
        play_stages(130, 0, 3, 400);
        run_ticks(100);
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        probe(snap(71, 0, 0, 1, 0, 3, 0, 1, 0, 1, 0, 0));

        // Clamped stage length on the second instance
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        sel = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        start_game(80);
        play_level(130, 0, 3, 1'b0, 500);
        run_ticks(39);
        probe(snap(81, 1, 0, 1, 1, 3, 39, 1, 0, 0, 0, 0));
        push_obj(82, 1, 1, 3, 40);
        run_ticks(1);
        for (int k = 2; k < 7; k++) begin
            push_obj(82 + k, k, 1, 3, 40 * k);
            run_ticks(40);
        end
        push_fin(90, 1, 3, 280);
        run_ticks(40);
        push_obj(91, 0, 2, 3, 0);
        run_ticks(390);
        play_level(40, 2, 3, 1'b1, 600);
        probe(snap(92, 0, 0, 0, 2, 3, 670, 1, 1, 0, 1, 0));
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        probe(snap(93, 0, 0, 0, 2, 3, 670, 1, 0, 1, 0, 0));

        end_req = 1'b1;
        @(posedge clk);
        #1;
        end_req = 1'b0;
        @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
